// File: rtl/branch_predictor_pkg.sv
// Shared constants and helpers for the BTB branch predictor.
// Counter helpers return the weak/saturated encodings for a given counter width.
package branch_predictor_pkg;

  localparam int ADDR_SIZE  = 32;
  localparam int INSTR_STEP = 4;

  typedef enum logic [1:0] {
    UPD_NONE  = 2'd0,
    UPD_TRAIN = 2'd1,
    UPD_JUMP  = 2'd2,
    UPD_ALLOC = 2'd3
  } upd_kind_e;

  function automatic int ctr_weak_taken(input int w);
    return 32'sd1 <<< (w - 32'sd1);
  endfunction

  function automatic int ctr_weak_not_taken(input int w);
    return (32'sd1 <<< (w - 32'sd1)) - 32'sd1;
  endfunction

  function automatic int ctr_max(input int w);
    return (32'sd1 <<< w) - 32'sd1;
  endfunction

endpackage

// File: rtl/branch_predictor_sat_counter.sv
// Saturating up/down counter with synchronous load; load has priority and
// simultaneous inc/dec holds the value.
module sat_counter #(
  parameter int           W       = 2,
  parameter logic [W-1:0] RST_VAL = {W{1'b0}}
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_inc,
  input  logic         i_dec,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic [W-1:0] o_count
);

  localparam logic [W-1:0] MAX_VAL = {W{1'b1}};
  localparam logic [W-1:0] MIN_VAL = {W{1'b0}};

  logic [W-1:0] r_count;
  logic [W-1:0] w_next;

  // Next-count selection with saturation at both ends
  always_comb begin
    w_next = r_count;
    if (i_load) begin
      w_next = i_load_val;
    end else if (i_inc && !i_dec) begin
      w_next = (r_count == MAX_VAL) ? r_count : r_count + W'(1);
    end else if (i_dec && !i_inc) begin
      w_next = (r_count == MIN_VAL) ? r_count : r_count - W'(1);
    end else begin
      w_next = r_count;
    end
  end

  // Count register
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_count <= RST_VAL;
    end else begin
      r_count <= w_next;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with per-entry direction counters.
// Lookup is combinational from registered state; training lands at the next edge.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int ADDR_W  = ADDR_SIZE,
  parameter int ENTRIES = 16,
  parameter int CTR_W   = 2,
  parameter int STAT_W  = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [ADDR_W-1:0] i_lookup_pc,
  output logic              o_pred_taken,
  output logic [ADDR_W-1:0] o_pred_target,
  input  logic              i_upd_valid,
  input  logic [ADDR_W-1:0] i_upd_pc,
  input  logic              i_upd_taken,
  input  logic [ADDR_W-1:0] i_upd_target,
  input  logic              i_upd_is_jump,
  input  logic              i_upd_mispredict,
  input  logic              i_flush_all,
  output logic [STAT_W-1:0] o_mispredict_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;
  localparam logic [CTR_W-1:0] CTR_MAX = CTR_W'(ctr_max(CTR_W));
  localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(ctr_weak_taken(CTR_W));
  localparam logic [CTR_W-1:0] CTR_WNT = CTR_W'(ctr_weak_not_taken(CTR_W));

  logic [ENTRIES-1:0] r_valid;
  logic [ENTRIES-1:0] r_is_jump;
  logic [TAG_W-1:0]   r_tag    [ENTRIES];
  logic [ADDR_W-1:0]  r_target [ENTRIES];
  logic [CTR_W-1:0]   w_ctr    [ENTRIES];

  // Word addresses: the byte offset within an instruction never takes part
  logic [ADDR_W-3:0] w_lk_word;
  logic [ADDR_W-3:0] w_up_word;
  logic [IDX_W-1:0]  w_lk_idx;
  logic [IDX_W-1:0]  w_up_idx;
  logic [TAG_W-1:0]  w_lk_tag;
  logic [TAG_W-1:0]  w_up_tag;
  logic              w_lk_hit;
  logic              w_up_hit;
  logic              w_do_upd;
  upd_kind_e         w_kind;

  assign w_lk_word = (ADDR_W-2)'(i_lookup_pc >> 2'd2);
  assign w_up_word = (ADDR_W-2)'(i_upd_pc >> 2'd2);
  assign w_lk_idx  = w_lk_word[IDX_W-1:0];
  assign w_up_idx  = w_up_word[IDX_W-1:0];
  assign w_lk_tag  = w_lk_word[ADDR_W-3:IDX_W];
  assign w_up_tag  = w_up_word[ADDR_W-3:IDX_W];

  assign w_lk_hit = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
  assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
  assign w_do_upd = i_upd_valid && !i_flush_all;

  assign o_pred_taken  = w_lk_hit && (r_is_jump[w_lk_idx] || w_ctr[w_lk_idx][CTR_W-1]);
  assign o_pred_target = o_pred_taken ? r_target[w_lk_idx]
                                      : i_lookup_pc + ADDR_W'(INSTR_STEP);

  // Classify the training request; gated on valid so idle X inputs stay inert
  always_comb begin
    w_kind = UPD_NONE;
    if (w_do_upd) begin
      if (w_up_hit) begin
        w_kind = i_upd_is_jump ? UPD_JUMP : UPD_TRAIN;
      end else if (i_upd_taken) begin
        w_kind = UPD_ALLOC;
      end else begin
        w_kind = UPD_NONE;
      end
    end else begin
      w_kind = UPD_NONE;
    end
  end

  for (genvar g = 0; g < ENTRIES; g++) begin : g_entry
    logic w_sel;
    assign w_sel = (w_kind != UPD_NONE) && (w_up_idx == IDX_W'(g));

    sat_counter #(
      .W       (CTR_W),
      .RST_VAL (CTR_WNT)
    ) u_dir_ctr (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_inc      (w_sel && (w_kind == UPD_TRAIN) && i_upd_taken),
      .i_dec      (w_sel && (w_kind == UPD_TRAIN) && !i_upd_taken),
      .i_load     (w_sel && ((w_kind == UPD_JUMP) || (w_kind == UPD_ALLOC))),
      .i_load_val ((w_kind == UPD_JUMP || i_upd_is_jump) ? CTR_MAX : CTR_WT),
      .o_count    (w_ctr[g])
    );
  end

  // Entry valid/tag/target/kind storage; flush wins over a same-cycle update
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_valid   <= {ENTRIES{1'b0}};
      r_is_jump <= {ENTRIES{1'b0}};
      for (int i = 0; i < ENTRIES; i++) begin
        r_tag[i]    <= {TAG_W{1'b0}};
        r_target[i] <= {ADDR_W{1'b0}};
      end
    end else if (i_flush_all) begin
      r_valid <= {ENTRIES{1'b0}};
    end else begin
      case (w_kind)
        UPD_ALLOC: begin
          r_valid[w_up_idx]   <= 1'b1;
          r_tag[w_up_idx]     <= w_up_tag;
          r_target[w_up_idx]  <= i_upd_target;
          r_is_jump[w_up_idx] <= i_upd_is_jump;
        end
        UPD_TRAIN: begin
          if (i_upd_taken) begin
            r_target[w_up_idx] <= i_upd_target;
          end
        end
        UPD_JUMP: begin
          r_target[w_up_idx] <= i_upd_target;
        end
        default: begin
          r_valid <= r_valid;
        end
      endcase
    end
  end

  sat_counter #(
    .W       (STAT_W),
    .RST_VAL ({STAT_W{1'b0}})
  ) u_mispredict_ctr (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_inc      (i_upd_valid && i_upd_mispredict),
    .i_dec      (1'b0),
    .i_load     (1'b0),
    .i_load_val ({STAT_W{1'b0}}),
    .o_count    (o_mispredict_cnt)
  );

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: expected lookups are queued when
// stimulus is applied and compared when the outputs are sampled.
module tb_branch_predictor;

  typedef struct {
    string       name;
    logic        taken;
    logic [31:0] target;
    logic [2:0]  cnt;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [31:0] lookup_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_is_jump;
  logic        upd_mispredict;
  logic        flush_all;
  logic [2:0]  mispredict_cnt;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  branch_predictor #(
    .ADDR_W  (32),
    .ENTRIES (16),
    .CTR_W   (2),
    .STAT_W  (3)
  ) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_lookup_pc      (lookup_pc),
    .o_pred_taken     (pred_taken),
    .o_pred_target    (pred_target),
    .i_upd_valid      (upd_valid),
    .i_upd_pc         (upd_pc),
    .i_upd_taken      (upd_taken),
    .i_upd_target     (upd_target),
    .i_upd_is_jump    (upd_is_jump),
    .i_upd_mispredict (upd_mispredict),
    .i_flush_all      (flush_all),
    .o_mispredict_cnt (mispredict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_upd(input logic v, input logic [31:0] pc, input logic tk,
                         input logic [31:0] tg, input logic j, input logic m);
    upd_valid      = v;
    upd_pc         = pc;
    upd_taken      = tk;
    upd_target     = tg;
    upd_is_jump    = j;
    upd_mispredict = m;
  endtask

  task automatic push_exp(input string n, input logic t, input logic [31:0] tg,
                          input logic [2:0] c);
    exp_t e;
    e.name   = n;
    e.taken  = t;
    e.target = tg;
    e.cnt    = c;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b0;
    flush_all = 1'b0;
    lookup_pc = 32'h0000_0100;
    set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    push_exp("reset_hold", 1'b0, 32'h0000_0104, 3'd0);
    @(negedge clk);
    e = sb.pop_front();
    n_cmp++;
    if ({pred_taken, pred_target} !== {e.taken, e.target}) begin
      n_bad++;
      $display("FAIL %s: taken/target got %0b/%h expected %0b/%h", e.name, pred_taken, pred_target, e.taken, e.target);
    end
    n_cmp++;
    if (mispredict_cnt !== e.cnt) begin
      n_bad++;
      $display("FAIL %s: cnt got %0d expected %0d", e.name, mispredict_cnt, e.cnt);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    push_exp("reset_release", 1'b0, 32'h0000_0104, 3'd0);
    @(negedge clk);
    e = sb.pop_front();
    n_cmp++;
    if ({pred_taken, pred_target} !== {e.taken, e.target}) begin
      n_bad++;
      $display("FAIL %s: taken/target got %0b/%h expected %0b/%h", e.name, pred_taken, pred_target, e.taken, e.target);
    end
    n_cmp++;
    if (mispredict_cnt !== e.cnt) begin
      n_bad++;
      $display("FAIL %s: cnt got %0d expected %0d", e.name, mispredict_cnt, e.cnt);
    end
  endtask

  task automatic test_alloc();
    exp_t e;
    @(posedge clk); #1;
    set_upd(1'b1, 32'h0000_0200, 1'b1, 32'h0000_0280, 1'b0, 1'b0);
    lookup_pc = 32'h0000_0200;
    push_exp("alloc_same_cycle", 1'b0, 32'h0000_0204, 3'd0);
    @(negedge clk);
    e = sb.pop_front();
    n_cmp++;
    if ({pred_taken, pred_target} !== {e.taken, e.target}) begin
      n_bad++;
      $display("FAIL %s: taken/target got %0b/%h expected %0b/%h", e.name, pred_taken, pred_target, e.taken, e.target);
    end
    @(posedge clk); #1;
    set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    push_exp("alloc_next_cycle", 1'b1, 32'h0000_0280, 3'd0);
    @(negedge clk);
    e = sb.pop_front();
    n_cmp++;
    if ({pred_taken, pred_target} !== {e.taken, e.target}) begin
      n_bad++;
      $display("FAIL %s: taken/target got %0b/%h expected %0b/%h", e.name, pred_taken, pred_target, e.taken, e.target);
    end
  endtask

  task automatic test_saturation();
    exp_t e;
    logic tk   [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic pred [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    lookup_pc = 32'h0000_0200;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      set_upd(1'b1, 32'h0000_0200, tk[i], 32'h0000_0280, 1'b0, 1'b0);
      @(posedge clk); #1;
      set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      push_exp($sformatf("sat_step%0d", i), pred[i],
               pred[i] ? 32'h0000_0280 : 32'h0000_0204, 3'd0);
      @(negedge clk);
      e = sb.pop_front();
      n_cmp++;
      if ({pred_taken, pred_target} !== {e.taken, e.target}) begin
        n_bad++;
        $display("FAIL %s: taken/target got %0b/%h expected %0b/%h", e.name, pred_taken, pred_target, e.taken, e.target);
      end
    end
  endtask

  task automatic test_alias();
    exp_t e;
    logic [31:0] pcs  [2] = '{32'h0000_0200, 32'h0000_0240};
    logic        tks  [2] = '{1'b0, 1'b1};
    logic [31:0] tgts [2] = '{32'h0000_0204, 32'h0000_02C0};
    @(posedge clk); #1;
    set_upd(1'b1, 32'h0000_0240, 1'b1, 32'h0000_02C0, 1'b0, 1'b0);
    @(posedge clk); #1;
    set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      lookup_pc = pcs[i];
      push_exp($sformatf("alias_%h", pcs[i]), tks[i], tgts[i], 3'd0);
      @(negedge clk);
      e = sb.pop_front();
      n_cmp++;
      if ({pred_taken, pred_target} !== {e.taken, e.target}) begin
        n_bad++;
        $display("FAIL %s: taken/target got %0b/%h expected %0b/%h", e.name, pred_taken, pred_target, e.taken, e.target);
      end
    end
  endtask

  task automatic test_jump_wrap();
    exp_t e;
    @(posedge clk); #1;
    lookup_pc = 32'hFFFF_FFFC;
    push_exp("wrap_miss", 1'b0, 32'h0000_0000, 3'd0);
    @(negedge clk);
    e = sb.pop_front();
    n_cmp++;
    if ({pred_taken, pred_target} !== {e.taken, e.target}) begin
      n_bad++;
      $display("FAIL %s: taken/target got %0b/%h expected %0b/%h", e.name, pred_taken, pred_target, e.taken, e.target);
    end
    @(posedge clk); #1;
    set_upd(1'b1, 32'hFFFF_FFFC, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
    @(posedge clk); #1;
    set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    push_exp("jump_hit", 1'b1, 32'h0000_0000, 3'd0);
    @(negedge clk);
    e = sb.pop_front();
    n_cmp++;
    if ({pred_taken, pred_target} !== {e.taken, e.target}) begin
      n_bad++;
      $display("FAIL %s: taken/target got %0b/%h expected %0b/%h", e.name, pred_taken, pred_target, e.taken, e.target);
    end
  endtask

  task automatic test_stats();
    exp_t e;
    lookup_pc = 32'h0000_0240;
    @(posedge clk); #1;
    set_upd(1'b1, 32'h0000_0500, 1'b0, 32'h0, 1'b0, 1'b1);
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (k == 9) begin
        upd_valid      = 1'b0;
        upd_pc         = 32'hxxxx_xxxx;
        upd_taken      = 1'bx;
        upd_target     = 32'hxxxx_xxxx;
        upd_is_jump    = 1'bx;
      end else if (k == 10) begin
        set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      end
      push_exp($sformatf("stat_cycle%0d", k), 1'b1, 32'h0000_02C0,
               (k > 7) ? 3'd7 : 3'(k));
      @(negedge clk);
      e = sb.pop_front();
      n_cmp++;
      if ({pred_taken, pred_target} !== {e.taken, e.target}) begin
        n_bad++;
        $display("FAIL %s: taken/target got %0b/%h expected %0b/%h", e.name, pred_taken, pred_target, e.taken, e.target);
      end
      n_cmp++;
      if (mispredict_cnt !== e.cnt) begin
        n_bad++;
        $display("FAIL %s: cnt got %0d expected %0d", e.name, mispredict_cnt, e.cnt);
      end
    end
  endtask

  task automatic test_flush();
    exp_t e;
    logic [31:0] pcs  [4] = '{32'h0000_0300, 32'h0000_0240, 32'hFFFF_FFFC, 32'h0000_0200};
    logic [31:0] tgts [4] = '{32'h0000_0304, 32'h0000_0244, 32'h0000_0000, 32'h0000_0204};
    @(posedge clk); #1;
    flush_all = 1'b1;
    set_upd(1'b1, 32'h0000_0300, 1'b1, 32'h0000_0380, 1'b0, 1'b1);
    @(posedge clk); #1;
    flush_all = 1'b0;
    set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      lookup_pc = pcs[i];
      push_exp($sformatf("flush_%h", pcs[i]), 1'b0, tgts[i], 3'd7);
      @(negedge clk);
      e = sb.pop_front();
      n_cmp++;
      if ({pred_taken, pred_target} !== {e.taken, e.target}) begin
        n_bad++;
        $display("FAIL %s: taken/target got %0b/%h expected %0b/%h", e.name, pred_taken, pred_target, e.taken, e.target);
      end
      n_cmp++;
      if (mispredict_cnt !== e.cnt) begin
        n_bad++;
        $display("FAIL %s: cnt got %0d expected %0d", e.name, mispredict_cnt, e.cnt);
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    @(posedge clk); #1;
    set_upd(1'b1, 32'h0000_0400, 1'b1, 32'h0000_0480, 1'b0, 1'b1);
    lookup_pc = 32'h0000_0400;
    #2;
    rst = 1'b0;
    @(posedge clk); #1;
    set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
        rst = 1'b1;
      end
      push_exp($sformatf("reset_mid%0d", i), 1'b0, 32'h0000_0404, 3'd0);
      @(negedge clk);
      e = sb.pop_front();
      n_cmp++;
      if ({pred_taken, pred_target} !== {e.taken, e.target}) begin
        n_bad++;
        $display("FAIL %s: taken/target got %0b/%h expected %0b/%h", e.name, pred_taken, pred_target, e.taken, e.target);
      end
      n_cmp++;
      if (mispredict_cnt !== e.cnt) begin
        n_bad++;
        $display("FAIL %s: cnt got %0d expected %0d", e.name, mispredict_cnt, e.cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_alloc();
    test_saturation();
    test_alias();
    test_jump_wrap();
    test_stats();
    test_flush();
    test_reset_mid();
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
